// File: rtl/fir_mac_ctrl_if.sv
// Handshake and memory/MAC bus between fir_mac_ctrl (master) and its
// sample source, coefficient loader, RAMs and MAC (slave).
interface fir_mac_ctrl_if #(
  parameter int SIZE        = 43,
  parameter int SAMPLE_SIZE = 16,
  parameter int COEFF_SIZE  = 16
);
  localparam int AW = $clog2(SIZE);
  localparam int DW = SAMPLE_SIZE + COEFF_SIZE + 1;

  logic                   s_valid;
  logic [SAMPLE_SIZE-1:0] s_data;
  logic                   s_ready;
  logic                   c_valid;
  logic [COEFF_SIZE-1:0]  c_data;
  logic                   c_ready;
  logic                   mac_en;
  logic                   WE;
  logic                   c_WE;
  logic [COEFF_SIZE-1:0]  c_in;
  logic [AW-1:0]          c_addr;
  logic [AW-1:0]          wr_addr_0;
  logic [AW-1:0]          wr_addr_1;
  logic [AW-1:0]          rd_addr_0;
  logic [AW-1:0]          rd_addr_1;
  logic [SAMPLE_SIZE-1:0] mem_in_0;
  logic [DW-1:0]          mac_dout;
  logic [DW-1:0]          y_data;
  logic                   y_valid;
  logic                   busy;

  modport master (
    input  s_valid, s_data, c_valid, c_data, mac_dout,
    output s_ready, c_ready, mac_en, WE, c_WE, c_in, c_addr,
           wr_addr_0, wr_addr_1, rd_addr_0, rd_addr_1, mem_in_0,
           y_data, y_valid, busy
  );

  modport slave (
    output s_valid, s_data, c_valid, c_data, mac_dout,
    input  s_ready, c_ready, mac_en, WE, c_WE, c_in, c_addr,
           wr_addr_0, wr_addr_1, rd_addr_0, rd_addr_1, mem_in_0,
           y_data, y_valid, busy
  );
endinterface

// File: rtl/fir_mac_ctrl.sv
// Sequencer for a symmetric 2*SIZE-tap FIR built from two delay-line RAMs and a MAC.
// Optional macro FIR_CTRL_COEFF_GUARD_EN blocks samples until a full coefficient set is loaded.
module fir_mac_ctrl #(
  parameter int SIZE        = 43,
  parameter int SAMPLE_SIZE = 16,
  parameter int COEFF_SIZE  = 16
) (
  input logic             clk,
  input logic             rst,
  fir_mac_ctrl_if.master  bus
);
  localparam int AW = $clog2(SIZE);
  localparam int DW = SAMPLE_SIZE + COEFF_SIZE + 1;
  localparam logic [AW-1:0] LAST   = AW'(SIZE - 1);
  localparam logic [AW-1:0] ZERO   = {AW{1'b0}};
  localparam logic [AW-1:0] ONE    = AW'(1);
  localparam logic [AW:0]   SIZE_W = (AW+1)'(SIZE);
  localparam logic [AW:0]   ONE_W  = (AW+1)'(1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WRITE = 3'd1,
    CLR   = 3'd2,
    CALC  = 3'd3,
    OUT   = 3'd4
  } state_t;

  state_t                 state_r, state_nxt_s;
  logic [AW-1:0]          ptr_r, k_r, load_cnt_r;
  logic [SAMPLE_SIZE-1:0] sample_r;
  logic [DW-1:0]          y_data_r;
  logic                   y_valid_r;
  logic                   coeff_ok_s;
  logic                   s_acc_s, c_acc_s;
  logic [AW:0]            ptr_w_s, k_w_s, rd0_s, rd1_s;

  logic                   s_ready_s, c_ready_s, mac_en_s, we_s, c_we_s, busy_s;
  logic [COEFF_SIZE-1:0]  c_in_s;
  logic [AW-1:0]          c_addr_s, wr_addr_0_s, wr_addr_1_s, rd_addr_0_s, rd_addr_1_s;
  logic [SAMPLE_SIZE-1:0] mem_in_0_s;

`ifdef FIR_CTRL_COEFF_GUARD_EN
  logic coeff_loaded_r;

  // Sticky flag: set once the load counter wraps after a full coefficient set
  always_ff @(posedge clk) begin
    if (!rst) begin
      coeff_loaded_r <= 1'b0;
    end else if (c_acc_s && (load_cnt_r == LAST)) begin
      coeff_loaded_r <= 1'b1;
    end else begin
      coeff_loaded_r <= coeff_loaded_r;
    end
  end

  assign coeff_ok_s = coeff_loaded_r;
`else
  assign coeff_ok_s = 1'b1;
`endif

  assign ptr_w_s = {1'b0, ptr_r};
  assign k_w_s   = {1'b0, k_r};

  // Circular read addresses: newest-to-oldest in RAM 0, oldest-to-newest in RAM 1
  always_comb begin
    if (ptr_w_s >= k_w_s) begin
      rd0_s = ptr_w_s - k_w_s;
    end else begin
      rd0_s = ptr_w_s + SIZE_W - k_w_s;
    end
    rd1_s = ptr_w_s + k_w_s + ONE_W;
    if (rd1_s >= SIZE_W) begin
      rd1_s = rd1_s - SIZE_W;
    end else begin
      rd1_s = rd1_s;
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-state strobes/addresses
  always_comb begin
    state_nxt_s = state_r;
    s_ready_s   = 1'b0;
    c_ready_s   = 1'b0;
    s_acc_s     = 1'b0;
    c_acc_s     = 1'b0;
    mac_en_s    = 1'b0;
    we_s        = 1'b0;
    c_we_s      = 1'b0;
    busy_s      = 1'b0;
    c_in_s      = {COEFF_SIZE{1'b0}};
    c_addr_s    = ZERO;
    wr_addr_0_s = ZERO;
    wr_addr_1_s = ZERO;
    rd_addr_0_s = ZERO;
    rd_addr_1_s = ZERO;
    mem_in_0_s  = {SAMPLE_SIZE{1'b0}};
    case (state_r)
      IDLE: begin
        c_ready_s = 1'b1;
        s_ready_s = ~bus.c_valid & coeff_ok_s;
        c_acc_s   = bus.c_valid;
        s_acc_s   = bus.s_valid & s_ready_s;
        if (c_acc_s) begin
          c_we_s   = 1'b1;
          c_addr_s = load_cnt_r;
          c_in_s   = bus.c_data;
        end else begin
          c_we_s   = 1'b0;
        end
        if (s_acc_s) begin
          state_nxt_s = WRITE;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WRITE: begin
        busy_s      = 1'b1;
        mac_en_s    = 1'b1;
        we_s        = 1'b1;
        wr_addr_0_s = ptr_r;
        wr_addr_1_s = ptr_r;
        rd_addr_0_s = ptr_r;
        mem_in_0_s  = sample_r;
        state_nxt_s = CLR;
      end
      CLR: begin
        busy_s      = 1'b1;
        mac_en_s    = 1'b1;
        state_nxt_s = CALC;
      end
      CALC: begin
        busy_s      = 1'b1;
        mac_en_s    = 1'b1;
        c_addr_s    = k_r;
        rd_addr_0_s = rd0_s[AW-1:0];
        rd_addr_1_s = rd1_s[AW-1:0];
        if (k_r == LAST) begin
          state_nxt_s = OUT;
        end else begin
          state_nxt_s = CALC;
        end
      end
      OUT: begin
        busy_s      = 1'b1;
        state_nxt_s = IDLE;
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // Head pointer, tap counter, coefficient load counter, sample and result registers
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_r      <= ZERO;
      k_r        <= ZERO;
      load_cnt_r <= ZERO;
      sample_r   <= {SAMPLE_SIZE{1'b0}};
      y_data_r   <= {DW{1'b0}};
      y_valid_r  <= 1'b0;
    end else begin
      y_valid_r <= (state_r == OUT);
      if (state_r == OUT) begin
        y_data_r <= bus.mac_dout;
        ptr_r    <= (ptr_r == LAST) ? ZERO : ptr_r + ONE;
      end
      if (state_r == CALC) begin
        k_r <= (k_r == LAST) ? ZERO : k_r + ONE;
      end else begin
        k_r <= ZERO;
      end
      if (c_acc_s) begin
        load_cnt_r <= (load_cnt_r == LAST) ? ZERO : load_cnt_r + ONE;
      end
      if (s_acc_s) begin
        sample_r <= bus.s_data;
      end
    end
  end

  assign bus.s_ready   = s_ready_s;
  assign bus.c_ready   = c_ready_s;
  assign bus.mac_en    = mac_en_s;
  assign bus.WE        = we_s;
  assign bus.c_WE      = c_we_s;
  assign bus.c_in      = c_in_s;
  assign bus.c_addr    = c_addr_s;
  assign bus.wr_addr_0 = wr_addr_0_s;
  assign bus.wr_addr_1 = wr_addr_1_s;
  assign bus.rd_addr_0 = rd_addr_0_s;
  assign bus.rd_addr_1 = rd_addr_1_s;
  assign bus.mem_in_0  = mem_in_0_s;
  assign bus.y_data    = y_data_r;
  assign bus.y_valid   = y_valid_r;
  assign bus.busy      = busy_s;
endmodule

// File: tb/tb_fir_mac_ctrl.sv
// Directed bench for fir_mac_ctrl with SIZE=4, driving a behavioural pair of
// delay-line RAMs, a coefficient RAM and a pre-add MAC scaled down by 8.
module tb_fir_mac_ctrl;
  localparam int SIZE = 4;
  localparam int SS   = 16;
  localparam int CS   = 16;
  localparam int AW   = 2;
  localparam int DW   = 33;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fir_mac_ctrl_if #(.SIZE(SIZE), .SAMPLE_SIZE(SS), .COEFF_SIZE(CS)) bus ();

  fir_mac_ctrl #(.SIZE(SIZE), .SAMPLE_SIZE(SS), .COEFF_SIZE(CS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Environment: RAM 0 takes new samples, RAM 1 takes the sample RAM 0 displaces
  logic [SS-1:0] ram0 [0:SIZE-1];
  logic [SS-1:0] ram1 [0:SIZE-1];
  logic [CS-1:0] cram [0:SIZE-1];
  logic [39:0]   acc;
  logic          we_d;
  logic [16:0]   pre;
  logic [39:0]   prod;

  assign pre  = {1'b0, ram0[bus.rd_addr_0]} + {1'b0, ram1[bus.rd_addr_1]};
  assign prod = 40'(pre) * 40'(cram[bus.c_addr]);
  assign bus.mac_dout = DW'(acc >> 3);

  always @(posedge clk) begin
    we_d <= bus.WE;
    if (bus.WE) begin
      ram0[bus.wr_addr_0] <= bus.mem_in_0;
      ram1[bus.wr_addr_1] <= ram0[bus.rd_addr_0];
    end
    if (bus.c_WE) cram[bus.c_addr] <= bus.c_in;
    if (bus.mac_en) acc <= we_d ? 40'd0 : acc + prod;
  end

  int n_cmp = 0;
  int n_err = 0;
  int exp_ptr = 0;

  typedef struct {
    logic [SS-1:0] sample;
    bit            check;
    logic [DW-1:0] exp_y;
  } vec_t;

  vec_t vecs [17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic load_coeffs();
    logic [CS-1:0] coef [4];
    coef = '{16'd8, 16'd16, 16'd24, 16'd32};
    for (int i = 0; i < 4; i++) begin
      bus.c_valid = 1'b1;
      bus.c_data  = coef[i];
      bus.s_valid = 1'b1;
      bus.s_data  = 16'd0;
      #1;
      chk("c_ready", 64'(bus.c_ready), 64'd1);
      chk("c_WE", 64'(bus.c_WE), 64'd1);
      chk("c_addr_load", 64'(bus.c_addr), 64'(i));
      chk("c_in", 64'(bus.c_in), 64'(coef[i]));
      chk("s_ready_conflict", 64'(bus.s_ready), 64'd0);
      @(negedge clk);
    end
    bus.c_valid = 1'b0;
    bus.s_valid = 1'b0;
    bus.c_data  = 16'd0;
    #1;
    chk("c_WE_idle", 64'(bus.c_WE), 64'd0);
    chk("s_ready_after_load", 64'(bus.s_ready), 64'd1);
  endtask

  // Called at a negedge; returns at the negedge of the y_valid cycle
  task automatic push(input logic [SS-1:0] v, input bit do_chk, input logic [DW-1:0] exp_y);
    int lat;
    int k;
    lat = -1;
    bus.s_valid = 1'b1;
    bus.s_data  = v;
    #1;
    for (int w = 0; w < 20 && !bus.s_ready; w++) begin
      @(negedge clk);
      #1;
    end
    chk("s_ready", 64'(bus.s_ready), 64'd1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = 16'd0;
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      if (j == 0) begin
        chk("WE", 64'(bus.WE), 64'd1);
        chk("wr_addr_0", 64'(bus.wr_addr_0), 64'(exp_ptr));
        chk("wr_addr_1", 64'(bus.wr_addr_1), 64'(exp_ptr));
        chk("rd_addr_0_write", 64'(bus.rd_addr_0), 64'(exp_ptr));
        chk("mem_in_0", 64'(bus.mem_in_0), 64'(v));
        chk("y_valid_single", 64'(bus.y_valid), 64'd0);
        chk("busy", 64'(bus.busy), 64'd1);
      end else if (j >= 2 && j <= 5) begin
        k = j - 2;
        chk("c_addr_calc", 64'(bus.c_addr), 64'(k));
        chk("rd_addr_0", 64'(bus.rd_addr_0), 64'((exp_ptr - k + SIZE) % SIZE));
        chk("rd_addr_1", 64'(bus.rd_addr_1), 64'((exp_ptr + 1 + k) % SIZE));
        chk("mac_en_calc", 64'(bus.mac_en), 64'd1);
      end else if (j == 6) begin
        chk("mac_en_out", 64'(bus.mac_en), 64'd0);
      end
      if (bus.y_valid) begin
        lat = j;
        break;
      end
    end
    chk("latency", 64'(lat), 64'd7);
    if (do_chk) chk("y_data", 64'(bus.y_data), 64'(exp_y));
    exp_ptr = (exp_ptr + 1) % SIZE;
  endtask

  initial begin
    int exp_tab [9];
    int seen;
    exp_tab = '{1, 2, 3, 4, 4, 3, 2, 1, 0};
    for (int i = 0; i < 17; i++) begin
      vecs[i].sample = (i == 8) ? 16'd1 : 16'd0;
      vecs[i].check  = (i >= 8);
      vecs[i].exp_y  = (i >= 8) ? DW'(exp_tab[i-8]) : {DW{1'b0}};
    end

    bus.s_valid = 1'b0;
    bus.s_data  = 16'd0;
    bus.c_valid = 1'b0;
    bus.c_data  = 16'd0;

    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_mac_en", 64'(bus.mac_en), 64'd0);
    chk("rst_WE", 64'(bus.WE), 64'd0);
    chk("rst_c_WE", 64'(bus.c_WE), 64'd0);
    chk("rst_y_valid", 64'(bus.y_valid), 64'd0);
    chk("rst_y_data", 64'(bus.y_data), 64'd0);
    chk("rst_c_ready", 64'(bus.c_ready), 64'd1);
    rst = 1'b1;
`ifdef FIR_CTRL_COEFF_GUARD_EN
    bus.s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("guard_s_ready", 64'(bus.s_ready), 64'd0);
      @(negedge clk);
    end
    bus.s_valid = 1'b0;
`else
    #1;
    chk("noguard_s_ready", 64'(bus.s_ready), 64'd1);
    @(negedge clk);
`endif

    load_coeffs();

    for (int i = 0; i < 17; i++) begin
      push(vecs[i].sample, vecs[i].check, vecs[i].exp_y);
    end
    @(negedge clk);
    chk("y_valid_drop", 64'(bus.y_valid), 64'd0);

    // Abort a computation with reset in the middle of CALC
    bus.s_valid = 1'b1;
    bus.s_data  = 16'd5;
    #1;
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_data  = 16'd0;
    repeat (4) @(negedge clk);
    chk("pre_abort_mac_en", 64'(bus.mac_en), 64'd1);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    chk("abort_mac_en", 64'(bus.mac_en), 64'd0);
    chk("abort_y_valid", 64'(bus.y_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.y_valid) seen++;
    end
    chk("abort_no_result", 64'(seen), 64'd0);

    // Pointer restarts at 0 after reset
    exp_ptr = 0;
    load_coeffs();
    push(16'd0, 1'b0, {DW{1'b0}});
    @(negedge clk);
    chk("y_valid_drop_final", 64'(bus.y_valid), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fir_mac_ctrl.md
FIR_MAC_CTRL -- requirements
Module: fir_mac_ctrl

Interface
REQ-001 SHALL have parameter SIZE, 43, taps per half of the symmetric 2*SIZE-tap filter (delay-line depth per RAM).
REQ-002 SHALL have parameter SAMPLE_SIZE, 16, sample width.
REQ-003 SHALL have parameter COEFF_SIZE, 16, coefficient width; AW = clog2(SIZE), DW = SAMPLE_SIZE+COEFF_SIZE+1.
REQ-004 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-low reset.
REQ-006 SHALL have ports s_valid  input  1 and s_data  input  SAMPLE_SIZE  for the input sample handshake.
REQ-007 SHALL have port s_ready  output  1  sample accepted on s_valid&s_ready.
REQ-008 SHALL have ports c_valid  input  1 and c_data  input  COEFF_SIZE  for the coefficient-load handshake.
REQ-009 SHALL have port c_ready  output  1  coefficient accepted on c_valid&c_ready.
REQ-010 SHALL have port mac_en  output  1  MAC clock enable.
REQ-011 SHALL have port WE  output  1  sample-RAM write strobe; c_WE  output  1  coefficient-RAM write strobe.
REQ-012 SHALL have port c_in  output  COEFF_SIZE  and c_addr  output  AW  for coefficient data and address.
REQ-013 SHALL have ports wr_addr_0, wr_addr_1  output  AW  sample-RAM write addresses.
REQ-014 SHALL have ports rd_addr_0, rd_addr_1  output  AW  sample-RAM read addresses.
REQ-015 SHALL have port mem_in_0  output  SAMPLE_SIZE  new sample to RAM 0; RAM 1 input is wired externally from MAC mem_out_0.
REQ-016 SHALL have port mac_dout  input  DW  MAC accumulator.
REQ-017 SHALL have ports y_data  output  DW  filter result, y_valid  output  1  one-cycle result strobe, busy  output  1  high outside IDLE.

Function
REQ-018 SHALL implement states IDLE, WRITE, CLR, CALC, OUT; IDLE->WRITE on sample accept, WRITE->CLR, CLR->CALC, CALC->OUT after SIZE cycles, OUT->IDLE.
REQ-019 SHALL assert s_ready only in IDLE with c_valid low (coefficient load wins simultaneous requests); s_data registered on accept.
REQ-020 SHALL assert c_ready only in IDLE; each accepted coefficient drives c_WE=1, c_in=c_data, c_addr=load counter in the same cycle; counter wraps SIZE-1->0.
REQ-021 SHALL hold head pointer ptr; WRITE: WE=1, wr_addr_0=wr_addr_1=rd_addr_0=ptr, mem_in_0=sample (RAM 1 receives the displaced oldest sample).
REQ-022 SHALL in CLR drive WE=0 with mac_en=1 so the MAC clears its accumulator at the edge ending CLR.
REQ-023 SHALL in CALC cycle k (0..SIZE-1) drive c_addr=k, rd_addr_0=(ptr-k) mod SIZE, rd_addr_1=(ptr+1+k) mod SIZE.
REQ-024 SHALL drive mac_en=1 in WRITE, CLR, CALC and 0 in IDLE and OUT, freezing the accumulator.
REQ-025 SHALL in OUT register y_data<=mac_dout and ptr<=(ptr+1) mod SIZE (SIZE-1 wraps to 0), pulsing y_valid for exactly the next cycle.
REQ-026 SHALL give latency: y_valid high SIZE+3 rising edges after the accept edge (46 for SIZE=43); a new sample may be accepted in the y_valid cycle.
REQ-027 SHALL hold WE, c_WE low and addresses at 0 whenever not specified above.

Reset
REQ-028 SHALL on rst=0 at a clock edge, including mid-CALC, enter IDLE and clear ptr, load counter, y_data, y_valid, WE, c_WE, mac_en, busy, aborting any result.
REQ-029 SHALL NOT clear RAM contents on reset; delay-line flush is the user's duty (2*SIZE zero samples).

Configuration
REQ-030 SHALL, with FIR_CTRL_COEFF_GUARD_EN defined, hold s_ready low after reset until SIZE coefficients have been loaded (sticky flag).
REQ-031 SHALL, without FIR_CTRL_COEFF_GUARD_EN, accept samples immediately after reset.

Verification (SIZE=4)
REQ-032 SHALL check: reset mid-CALC -> next cycle busy=0, mac_en=0, y_valid never pulses for the aborted sample.
REQ-033 SHALL check: load coeffs 8,16,24,32 -> c_WE pulses with c_addr 0,1,2,3; then push 8 zeros then impulse 1 then zeros -> y_data sequence 1,2,3,4,4,3,2,1,0.
REQ-034 SHALL check: accept edge -> y_valid exactly 7 edges later, single cycle; rd_addr_0/rd_addr_1 per REQ-023 across ptr wrap 3->0.
REQ-035 SHALL check: c_valid and s_valid both high in IDLE -> coefficient taken, s_ready=0 that cycle.
REQ-036 SHALL check: with FIR_CTRL_COEFF_GUARD_EN, s_valid held high after reset -> s_ready=0 until 4th coefficient accepted.
